// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared MUX_WIDTH-input mux.
// One owner at a time; a hold limit forces rotation while others are waiting.
module mux_rr_arbiter #(
  parameter int MUX_WIDTH = 16,
  parameter int MAX_HOLD  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MUX_WIDTH-1:0]         req,
  input  logic                         done,
  output logic [MUX_WIDTH-1:0]         grant,
  output logic [$clog2(MUX_WIDTH)-1:0] sel,
  output logic                         valid
);

  localparam int SW = $clog2(MUX_WIDTH);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_reg;
  logic [MUX_WIDTH-1:0] grant_reg;
  logic [SW-1:0]        sel_reg;
  logic [SW-1:0]        owner_reg;
  logic [SW-1:0]        ptr_reg;
  logic [HW-1:0]        hold_reg;

  logic [MUX_WIDTH-1:0] other_req;
  logic [MUX_WIDTH-1:0] cand_onehot;
  logic                 others_pending;
  logic                 rel_now;
  logic [SW-1:0]        start_next;
  logic                 cand_found;
  logic [SW-1:0]        cand_idx;

  genvar gi;
  generate
    for (gi = 0; gi < MUX_WIDTH; gi++) begin : g_bits
      assign other_req[gi]   = req[gi] && (owner_reg != SW'(gi));
      assign cand_onehot[gi] = (cand_idx == SW'(gi));
    end
  endgenerate

  assign others_pending = |other_req;
  assign rel_now = (state_reg == BUSY) &&
                   (done || !req[owner_reg] || ((hold_reg == HOLD_LAST) && others_pending));
  // The releasing owner goes to the back of the line.
  assign start_next = rel_now ? (owner_reg + SW'(1)) : ptr_reg;

  // Walk offsets from the far end down so the nearest requester wins.
  always_comb begin : scan_p
    logic [SW-1:0] idx;
    idx        = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = MUX_WIDTH - 1; k >= 0; k--) begin
      idx = start_next + SW'(k);
      if (req[idx]) begin
        cand_found = 1'b1;
        cand_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      sel_reg   <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      hold_reg  <= '0;
    end else if (state_reg == IDLE || rel_now) begin
      if (rel_now) begin
        ptr_reg <= start_next;
      end
      hold_reg <= '0;
      if (cand_found) begin
        state_reg <= BUSY;
        owner_reg <= cand_idx;
        sel_reg   <= cand_idx;
        grant_reg <= cand_onehot;
      end else begin
        state_reg <= IDLE;
        grant_reg <= '0;
      end
    end else if (hold_reg != HOLD_LAST) begin
      hold_reg <= hold_reg + HW'(1);
    end
  end

  assign grant = grant_reg;
  assign sel   = sel_reg;
  assign valid = (state_reg == BUSY);

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one MUX_WIDTH-input Mux among MUX_WIDTH requesters and drives the Mux select. Each requester raises a request line, and the arbiter grants exactly one owner at a time. It presents that owner's index on the select bus for as long as the owner holds the grant. A hold limit forces rotation when other requesters are waiting, so no requester starves. It sits directly in front of the shared Mux in the issue/writeback path.

## Interface
- MUX_WIDTH, 16, number of requesters; must be a power of 2, ≥ 2
- MAX_HOLD, 4, maximum consecutive grant cycles for one owner while others wait; ≥ 1
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  MUX_WIDTH  request vector, bit i = requester i wants the Mux
- done  input  1  current owner releases the grant this cycle
- grant  output  MUX_WIDTH  one-hot grant, registered; all zero when idle
- sel  output  $clog2(MUX_WIDTH)  Mux select = index of current owner, registered
- valid  output  1  a grant is active, registered

## Operation
- State registers:
  - valid
  - owner (index)
  - ptr: round-robin start index, $clog2(MUX_WIDTH) bits, wraps modulo MUX_WIDTH
  - hold_cnt: 0..MAX_HOLD-1, saturating
- Two states, IDLE (valid=0) and BUSY (valid=1).
- others_pending = any req bit set other than req[owner].
- release (BUSY only) is true when any of the following holds:
  - done=1
  - req[owner]=0
  - hold_cnt==MAX_HOLD-1 and others_pending=1
- Arbitration is evaluated when valid=0 or release=1:
  - On release, the search start is owner+1 mod MUX_WIDTH, and ptr is written with that value.
  - In IDLE, the search start is ptr.
  - Scan upward from the start with wrap-around. The first i with req[i]=1 becomes the candidate.
  - If there is a candidate: valid←1, owner←i, sel←i, grant←one-hot(i), hold_cnt←0. The releasing owner is lowest priority but may be regranted if it is the only requester.
  - If there is no candidate: valid←0, grant←0, sel holds its last value, ptr as above.
- BUSY without release: grant, sel and owner hold, and hold_cnt increments (saturating).
- The timeout applies only when others_pending=1. A lone requester keeps the grant indefinitely.
- grant is always one-hot or zero. grant[sel]==valid at all times.

## Timing
- Reset (reset=1 at an edge) sets:
  - valid=0, grant=0, sel=0
  - ptr=0, hold_cnt=0, owner=0
- Reset overrides everything, including a reset asserted mid-grant, and takes effect on the same edge.
- Request to grant latency is 1 cycle. A req seen at edge N with the arbiter IDLE gives grant valid after edge N.
- Handover has zero bubble: the edge that releases one owner installs the next one.
- done is sampled only while valid=1; done=1 in IDLE is ignored.
- Under continuous contention, one owner holds for at most MAX_HOLD cycles.
- The first grant after reset goes to the lowest-index active requester, because ptr=0.

## Test plan
- **Reset:** reset=1 for 2 cycles with req=16'hFFFF.
  - During reset: grant=0, valid=0, sel=0.
  - First edge after release: grant=16'h0001, sel=0, valid=1.
- **Single requester:** req=16'h0100, done=0 held for 10 cycles.
  - One cycle later: sel=8, grant=16'h0100.
  - Grant is held for all 10 cycles; no timeout because nothing else is pending.
- **Round-robin with done:** req=16'h8101 held, done=1 held.
  - sel sequence 0,8,15,0,8,15…, one cycle each, valid stays 1.
- **Timeout:** req=16'h0003, done=0.
  - sel=0 for 4 cycles, then sel=1 for 4 cycles, alternating with no idle gap.
- **Owner drop:** owner sel=8 with req=16'h0120.
  - Drop bit 8 (req=16'h0020): next edge sel=5, grant=16'h0020.
  - Then req=0: next edge valid=0, grant=0, sel stays 5.
- **Reset mid-grant:** grant on sel=12 with req=16'hF000, then pulse reset for 1 cycle.
  - During reset: valid=0, grant=0, sel=0.
  - Next edge after release: sel=12, because the ptr=0 scan finds 12 first.
